// File: rtl/fir_mac_seq_pkg.sv
// Shared definitions for the FIR MAC sequencer: default sizes and FSM state encoding.
package fir_mac_seq_pkg;

  localparam int NYQ_WIDTH = 24;
  localparam int NYQ_NTAPS = 8;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_CLR  = 3'd1,
    ST_ACC  = 3'd2,
    ST_CAP  = 3'd3,
    ST_OUT  = 3'd4
  } state_t;

endpackage

// File: rtl/fir_mac_seq_sample_ring.sv
// Circular sample delay line: one write port, one combinational indexed read port.
// Every entry clears to zero on reset so early outputs see a silent history.
module fir_mac_seq_sample_ring #(
  parameter int WIDTH = 24,
  parameter int NTAPS = 8,
  localparam int CNT_W = $clog2(NTAPS)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [CNT_W-1:0] wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic [CNT_W-1:0] rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [NTAPS-1:0][WIDTH-1:0] mem_rd;

  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_entry
    logic [WIDTH-1:0] entry_reg;

    // Capture the incoming sample when this slot is the write target.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        entry_reg <= '0;
      end else if (wr_en && (wr_addr == CNT_W'(gi))) begin
        entry_reg <= wr_data;
      end
    end

    assign mem_rd[gi] = entry_reg;
  end

  assign rd_data = mem_rd[rd_addr];

endmodule

// File: rtl/fir_mac_seq.sv
// FIR sequencer: buffers samples, holds coefficients and drives an external MAC
// through one clear plus NTAPS accumulate strobes per sample, then presents the result.
module fir_mac_seq
  import fir_mac_seq_pkg::*;
#(
  parameter int WIDTH = NYQ_WIDTH,
  parameter int NTAPS = NYQ_NTAPS,
  localparam int CNT_W = $clog2(NTAPS)
) (
  input  logic             Clk_CI,
  input  logic             Rst_RBI,
  input  logic             InValid_SI,
  output logic             InReady_SO,
  input  logic [WIDTH-1:0] In_DI,
  input  logic             CoefWrEn_SI,
  input  logic [CNT_W-1:0] CoefAddr_SI,
  input  logic [WIDTH-1:0] Coef_DI,
  output logic             MacClr_SO,
  output logic             MacWrEn_SO,
  output logic [WIDTH-1:0] MacIn0_DO,
  output logic [WIDTH-1:0] MacIn1_DO,
  input  logic [WIDTH-1:0] MacOut_DI,
  output logic             OutValid_SO,
  input  logic             OutReady_SI,
  output logic [WIDTH-1:0] Out_DO
);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] wp_reg, wp_next;
  logic [CNT_W-1:0] k_reg, k_next;
  logic [WIDTH-1:0] out_reg, out_next;

  logic             in_idle;
  logic             accept;
  logic             coef_we;
  logic [CNT_W-1:0] wr_ptr;
  logic [CNT_W-1:0] rd_ptr;
  logic [WIDTH-1:0] ring_rd;
  logic [NTAPS-1:0][WIDTH-1:0] coef_bank;

  assign in_idle = (state_reg == ST_IDLE);
  assign accept  = InValid_SI && in_idle;
  // Coefficients may only change while no filter pass is in flight.
  assign coef_we = CoefWrEn_SI && in_idle;
  // New sample goes one slot ahead of the newest; tap k reads k slots behind it.
  assign wr_ptr  = wp_reg + CNT_W'(1);
  assign rd_ptr  = wp_reg - k_reg;

  fir_mac_seq_sample_ring #(
    .WIDTH (WIDTH),
    .NTAPS (NTAPS)
  ) u_ring (
    .clk     (Clk_CI),
    .rst_n   (Rst_RBI),
    .wr_en   (accept),
    .wr_addr (wr_ptr),
    .wr_data (In_DI),
    .rd_addr (rd_ptr),
    .rd_data (ring_rd)
  );

  for (genvar gi = 0; gi < NTAPS; gi++) begin : g_coef
    logic [WIDTH-1:0] coef_entry_reg;

    // Load this coefficient when addressed during IDLE.
    always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
      if (!Rst_RBI) begin
        coef_entry_reg <= '0;
      end else if (coef_we && (CoefAddr_SI == CNT_W'(gi))) begin
        coef_entry_reg <= Coef_DI;
      end
    end

    assign coef_bank[gi] = coef_entry_reg;
  end

  // State, pointers and result register.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      state_reg <= ST_IDLE;
      wp_reg    <= '0;
      k_reg     <= '0;
      out_reg   <= '0;
    end else begin
      state_reg <= state_next;
      wp_reg    <= wp_next;
      k_reg     <= k_next;
      out_reg   <= out_next;
    end
  end

  // Next-state and MAC control; MAC pins stay quiet outside CLR/ACC.
  always_comb begin
    state_next  = state_reg;
    wp_next     = wp_reg;
    k_next      = k_reg;
    out_next    = out_reg;
    InReady_SO  = 1'b0;
    MacClr_SO   = 1'b0;
    MacWrEn_SO  = 1'b0;
    MacIn0_DO   = '0;
    MacIn1_DO   = '0;
    OutValid_SO = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        InReady_SO = 1'b1;
        if (InValid_SI) begin
          wp_next    = wr_ptr;
          state_next = ST_CLR;
        end
      end
      ST_CLR: begin
        MacWrEn_SO = 1'b1;
        MacClr_SO  = 1'b1;
        k_next     = '0;
        state_next = ST_ACC;
      end
      ST_ACC: begin
        MacWrEn_SO = 1'b1;
        MacIn0_DO  = ring_rd;
        MacIn1_DO  = coef_bank[k_reg];
        k_next     = k_reg + CNT_W'(1);
        if (k_reg == CNT_W'(NTAPS - 1)) begin
          state_next = ST_CAP;
        end
      end
      ST_CAP: begin
        // MAC output is settled one cycle after the last accumulate strobe.
        out_next   = MacOut_DI;
        state_next = ST_OUT;
      end
      ST_OUT: begin
        OutValid_SO = 1'b1;
        if (OutReady_SI) begin
          state_next = ST_IDLE;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign Out_DO = out_reg;

endmodule
